// File: rtl/trim_pkg.sv
// Shared trim-path constants: word width, system clock rate and receiver state encodings.
// The generator uses the same encodings, so keep the two sides in step.
package trim_pkg;

  localparam int TRIM_WIDTH = 12;
  localparam int CLK_HZ     = 50_000_000;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one async input plus rise/fall detect on the synced value.
// Latency: STAGES cycles to sync; edges are flagged combinationally in the following cycle.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic CLK50,
  input  logic RST,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              sync_d;

  always_ff @(posedge CLK50) begin
    if (RST) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      sync_d <= sync_q[STAGES-1];
    end
  end

  assign sync = sync_q[STAGES-1];
  assign rise = sync & ~sync_d;
  assign fall = ~sync & sync_d;

endmodule

// File: rtl/trim_serial_rx.sv
// Rebuilds LSB-first trim words from the oversampled DIN/ENCLK_IN stream; a frame closes after ENCLK idles low.
// Latency: last ENCLK edge to TRIM_VALID is SYNC_STAGES+IDLE_CYCLES+1 cycles; no backpressure, output just holds.
module trim_serial_rx
  import trim_pkg::*;
#(
  parameter int WIDTH       = TRIM_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CYCLES = CLK_HZ,
  parameter int CNT_W       = 5
) (
  input  logic             CLK50,
  input  logic             RST,
  input  logic             DIN,
  input  logic             ENCLK_IN,
  output logic [WIDTH-1:0] TRIM_OUT,
  output logic             TRIM_VALID,
  output logic             FRAME_ERR,
  output logic [CNT_W-1:0] BITS_RX,
  output logic             BUSY
);

  localparam int                 IDLE_W    = $clog2(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WIDTH_C   = CNT_W'(WIDTH);

  if ((2 ** CNT_W) - 1 < WIDTH) begin : g_cnt_w_chk
    $error("trim_serial_rx: CNT_W too narrow to count WIDTH bits");
  end
  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("trim_serial_rx: SYNC_STAGES must be at least 2");
  end

  logic enc_s, enc_rise, enc_fall;
  logic din_s, din_rise_unused, din_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_enclk (
    .CLK50 (CLK50),
    .RST   (RST),
    .d     (ENCLK_IN),
    .sync  (enc_s),
    .rise  (enc_rise),
    .fall  (enc_fall)
  );

  // Same depth as the ENCLK path so a fall lines up with the data it strobes.
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
    .CLK50 (CLK50),
    .RST   (RST),
    .d     (DIN),
    .sync  (din_s),
    .rise  (din_rise_unused),
    .fall  (din_fall_unused)
  );

  rx_state_t         state, state_nxt;
  logic [WIDTH-1:0]  shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic start, shift_en, cnt_en, idle_clr, idle_inc, close_good, close_err;

  always_ff @(posedge CLK50) begin
    if (RST) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    cnt_en     = 1'b0;
    idle_clr   = 1'b0;
    idle_inc   = 1'b0;
    close_good = 1'b0;
    close_err  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (enc_rise) begin
          state_nxt = RX_RECV;
          start     = 1'b1;
        end
      end
      RX_RECV: begin
        if (enc_fall) begin
          cnt_en   = 1'b1;
          shift_en = (bit_cnt < WIDTH_C);
        end
        // Any edge in the timeout cycle keeps the frame open.
        if (enc_rise || enc_fall || enc_s) begin
          idle_clr = 1'b1;
        end else if (idle_cnt == IDLE_LAST) begin
          state_nxt  = RX_IDLE;
          close_good = (bit_cnt >= WIDTH_C);
          close_err  = (bit_cnt < WIDTH_C);
        end else begin
          idle_inc = 1'b1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK50) begin
    if (RST) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      TRIM_OUT   <= '0;
      TRIM_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      BITS_RX    <= '0;
      BUSY       <= 1'b0;
    end else begin
      TRIM_VALID <= close_good;
      FRAME_ERR  <= close_err;

      if (start) begin
        shreg    <= '0;
        bit_cnt  <= '0;
        idle_cnt <= '0;
        BUSY     <= 1'b1;
      end else begin
        if (shift_en) shreg <= {din_s, shreg[WIDTH-1:1]};
        if (cnt_en && (bit_cnt != {CNT_W{1'b1}})) bit_cnt <= bit_cnt + CNT_W'(1);
        if (idle_clr)      idle_cnt <= '0;
        else if (idle_inc) idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      if (close_good) TRIM_OUT <= shreg;
      if (close_good || close_err) begin
        BITS_RX <= bit_cnt;
        BUSY    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trim_serial_rx.sv
// Directed bench for trim_serial_rx: good, long, short and gap-boundary frames with hand-computed results.
module tb_trim_serial_rx;

  localparam int WIDTH = 12;
  localparam int CNT_W = 5;
  localparam int HALF  = 8;
  localparam int IDLE  = 64;
  localparam int LAT   = 2 + IDLE + 1;

  logic             CLK50 = 1'b0;
  logic             RST = 1'b1;
  logic             DIN = 1'b0;
  logic             ENCLK_IN = 1'b0;
  logic [WIDTH-1:0] TRIM_OUT;
  logic             TRIM_VALID;
  logic             FRAME_ERR;
  logic [CNT_W-1:0] BITS_RX;
  logic             BUSY;

  trim_serial_rx #(
    .WIDTH(WIDTH), .SYNC_STAGES(2), .IDLE_CYCLES(IDLE), .CNT_W(CNT_W)
  ) dut (
    .CLK50      (CLK50),
    .RST        (RST),
    .DIN        (DIN),
    .ENCLK_IN   (ENCLK_IN),
    .TRIM_OUT   (TRIM_OUT),
    .TRIM_VALID (TRIM_VALID),
    .FRAME_ERR  (FRAME_ERR),
    .BITS_RX    (BITS_RX),
    .BUSY       (BUSY)
  );

  always #10 CLK50 = ~CLK50;

  int cyc = 0;
  always @(posedge CLK50) cyc <= cyc + 1;

  int               vld_cnt = 0;
  int               err_cnt = 0;
  int               vld_cyc = 0;
  int               fall_cyc = 0;
  logic [WIDTH-1:0] last_trim = '0;

  always @(negedge CLK50) begin
    if (TRIM_VALID) begin
      vld_cnt   = vld_cnt + 1;
      last_trim = TRIM_OUT;
      vld_cyc   = cyc;
    end
    if (FRAME_ERR) err_cnt = err_cnt + 1;
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK50);
      #1;
    end
  endtask

  // One ENCLK pulse; DIN changes at the rise. With scr set, DIN is flipped mid-low to prove
  // that only the value at the fall is captured.
  task automatic send_bit(input logic b, input int low_len, input bit scr);
    DIN      = b;
    ENCLK_IN = 1'b1;
    tick(HALF);
    ENCLK_IN = 1'b0;
    fall_cyc = cyc;
    if (scr && low_len > 4) begin
      tick(4);
      DIN = ~b;
      tick(low_len - 4);
    end else begin
      tick(low_len);
    end
  endtask

  task automatic send_frame(input logic [15:0] word, input int nbits, input bit scr);
    for (int i = 0; i < nbits; i++)
      send_bit(word[i], (i == nbits - 1) ? 0 : HALF, scr);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_trim", 32'(TRIM_OUT), 32'h0);
    chk("rst_bits", 32'(BITS_RX), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_vld", 32'(TRIM_VALID), 32'h0);
    RST = 1'b0;
    tick(2);

    // Good frame
    send_frame(16'h0A5C, 12, 1'b0);
    tick(100);
    chk("good_vld_cnt", 32'(vld_cnt), 32'd1);
    chk("good_trim", 32'(TRIM_OUT), 32'hA5C);
    chk("good_pulse_val", 32'(last_trim), 32'hA5C);
    chk("good_bits", 32'(BITS_RX), 32'd12);
    chk("good_latency", 32'(vld_cyc - fall_cyc), 32'(LAT));
    chk("good_busy", 32'(BUSY), 32'h0);

    // Reset mid-frame: partial frame dropped, outputs cleared, no pulse
    for (int i = 0; i < 5; i++) send_bit(1'b1, HALF, 1'b0);
    chk("mid_busy", 32'(BUSY), 32'h1);
    DIN = 1'b0;
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    chk("mrst_trim", 32'(TRIM_OUT), 32'h0);
    chk("mrst_bits", 32'(BITS_RX), 32'h0);
    chk("mrst_busy", 32'(BUSY), 32'h0);
    tick(100);
    chk("mrst_no_vld", 32'(vld_cnt), 32'd1);
    chk("mrst_no_err", 32'(err_cnt), 32'd0);

    // Over-length frame: 14 pulses, bits 12,13 copy bit 11
    send_frame(16'h3801, 14, 1'b0);
    tick(100);
    chk("long_vld_cnt", 32'(vld_cnt), 32'd2);
    chk("long_trim", 32'(TRIM_OUT), 32'h801);
    chk("long_bits", 32'(BITS_RX), 32'd14);

    // Good 0x123 then a 7-pulse short frame
    send_frame(16'h0123, 12, 1'b0);
    tick(100);
    chk("pre_short_trim", 32'(TRIM_OUT), 32'h123);
    send_frame(16'h007F, 7, 1'b0);
    tick(100);
    chk("short_err_cnt", 32'(err_cnt), 32'd1);
    chk("short_vld_cnt", 32'(vld_cnt), 32'd3);
    chk("short_bits", 32'(BITS_RX), 32'd7);
    chk("short_trim", 32'(TRIM_OUT), 32'h123);

    // Gap boundary: 62/63/64-cycle lows between bits must not close the frame
    begin
      logic [15:0] w;
      w = 16'h03C6;
      for (int i = 0; i < 12; i++)
        send_bit(w[i], (i == 11) ? 0 : (62 + (i % 3)), 1'b0);
    end
    chk("gap_no_vld", 32'(vld_cnt), 32'd3);
    chk("gap_no_err", 32'(err_cnt), 32'd1);
    chk("gap_busy", 32'(BUSY), 32'h1);
    tick(100);
    chk("gap_vld_cnt", 32'(vld_cnt), 32'd4);
    chk("gap_trim", 32'(TRIM_OUT), 32'h3C6);
    chk("gap_bits", 32'(BITS_RX), 32'd12);

    // Back-to-back 0x000 / 0xFFF with DIN scrambled during the low phase
    send_frame(16'h0000, 12, 1'b1);
    tick(100);
    chk("b2b0_vld_cnt", 32'(vld_cnt), 32'd5);
    chk("b2b0_val", 32'(last_trim), 32'h000);
    send_frame(16'h0FFF, 12, 1'b1);
    tick(100);
    chk("b2b1_vld_cnt", 32'(vld_cnt), 32'd6);
    chk("b2b1_val", 32'(last_trim), 32'hFFF);
    chk("b2b1_bits", 32'(BITS_RX), 32'd12);
    chk("b2b_err_cnt", 32'(err_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
